// File: rtl/seq_lock_pkg.sv
// Shared types and constants for the sequence-lock controller.
// State encoding, lockout limits, power-on code and the LED map per state.
package seq_lock_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_B1   = 3'd1,
    ST_B2   = 3'd2,
    ST_B3   = 3'd3,
    ST_OK   = 3'd4,
    ST_LOCK = 3'd5
  } state_t;

  localparam logic [1:0] MAX_FAIL      = 2'd3;
  localparam int         LOCK_STEPS    = 8;
  localparam logic [3:0] RESET_PATTERN = 4'b1011;

  function automatic logic [3:0] leds_for(state_t s);
    logic [3:0] leds;
    leds = 4'b0000;
    case (s)
      ST_B1:   leds = 4'b1000;
      ST_B2:   leds = 4'b0100;
      ST_B3:   leds = 4'b0010;
      ST_OK:   leds = 4'b0001;
      ST_LOCK: leds = 4'b1111;
      default: leds = 4'b0000;
    endcase
    return leds;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-sample pushbutton debouncer: btn_db high only when two consecutive sample ticks saw boton high.
// Latency two sample ticks; no backpressure, sampling is paced by sample_tick only.
module btn_debounce (
  input  logic clk,
  input  logic rst_n,
  input  logic sample_tick,
  input  logic boton,
  output logic btn_db
);

  logic d1;
  logic d2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d1 <= 1'b0;
      d2 <= 1'b0;
    end else if (sample_tick) begin
      d1 <= boton;
      d2 <= d1;
    end
  end

  assign btn_db = d1 & d2;

endmodule

// File: rtl/seq_lock_ctrl.sv
// Sequence lock: four button samples (one per step tick) compared with a programmable code, lockout after 3 misses.
// Outputs registered, updated one clk after step_tick; no backpressure, cfg_we outside IDLE is dropped and flagged.
module seq_lock_ctrl
  import seq_lock_pkg::*;
#(
  parameter int SAMPLE_BIT = 19,
  parameter int STEP_BIT   = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       boton,
  input  logic       cfg_we,
  input  logic [3:0] cfg_pattern,
  output logic       seq_ok,
  output logic [3:0] step_leds,
  output logic [1:0] fail_cnt,
  output logic       locked,
  output logic       cfg_err
);

  logic [STEP_BIT-1:0] div;
  logic                sample_tick;
  logic                step_tick;
  logic                btn_db;
  state_t              state;
  logic [1:0]          cap;
  logic [3:0]          pattern;
  logic [2:0]          lock_cnt;
  logic                unused_cfg_msb;

  // The code always starts with a 1, so the written MSB carries no information.
  assign unused_cfg_msb = cfg_pattern[3];

  assign sample_tick = &div[SAMPLE_BIT-1:0];
  assign step_tick   = &div;

  btn_debounce u_debounce (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_tick (sample_tick),
    .boton       (boton),
    .btn_db      (btn_db)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div       <= '0;
      state     <= ST_IDLE;
      cap       <= 2'b00;
      pattern   <= RESET_PATTERN;
      lock_cnt  <= 3'd0;
      fail_cnt  <= 2'd0;
      seq_ok    <= 1'b0;
      locked    <= 1'b0;
      cfg_err   <= 1'b0;
      step_leds <= 4'b0000;
    end else begin
      div     <= div + STEP_BIT'(1);
      cfg_err <= 1'b0;

      if (cfg_we) begin
        if (state == ST_IDLE) pattern <= {1'b1, cfg_pattern[2:0]};
        else                  cfg_err <= 1'b1;
      end

      if (step_tick) begin
        case (state)
          ST_IDLE: begin
            if (btn_db) begin
              state     <= ST_B1;
              step_leds <= leds_for(ST_B1);
            end
          end
          ST_B1: begin
            cap[1]    <= btn_db;
            state     <= ST_B2;
            step_leds <= leds_for(ST_B2);
          end
          ST_B2: begin
            cap[0]    <= btn_db;
            state     <= ST_B3;
            step_leds <= leds_for(ST_B3);
          end
          ST_B3: begin
            if ({1'b1, cap, btn_db} == pattern) begin
              state     <= ST_OK;
              seq_ok    <= 1'b1;
              fail_cnt  <= 2'd0;
              step_leds <= leds_for(ST_OK);
            end else if (fail_cnt == MAX_FAIL - 2'd1) begin
              state     <= ST_LOCK;
              locked    <= 1'b1;
              fail_cnt  <= MAX_FAIL;
              lock_cnt  <= 3'd0;
              step_leds <= leds_for(ST_LOCK);
            end else begin
              state     <= ST_IDLE;
              fail_cnt  <= fail_cnt + 2'd1;
              step_leds <= leds_for(ST_IDLE);
            end
          end
          ST_OK: begin
            state     <= ST_IDLE;
            seq_ok    <= 1'b0;
            step_leds <= leds_for(ST_IDLE);
          end
          ST_LOCK: begin
            // Button is deliberately ignored for the whole lockout window.
            if (lock_cnt == 3'(LOCK_STEPS - 1)) begin
              state     <= ST_IDLE;
              locked    <= 1'b0;
              lock_cnt  <= 3'd0;
              fail_cnt  <= 2'd0;
              step_leds <= leds_for(ST_IDLE);
            end else begin
              lock_cnt <= lock_cnt + 3'd1;
            end
          end
          default: begin
            state     <= ST_IDLE;
            step_leds <= leds_for(ST_IDLE);
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seq_lock_ctrl.sv
// Directed plus random bench for seq_lock_ctrl with a step period of 16 clocks.
// Expected behaviour comes from an attempt-level model: collected bits, code word, miss count, lockout countdown.
module tb_seq_lock_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       boton = 1'b0;
  logic       cfg_we = 1'b0;
  logic [3:0] cfg_pattern = 4'b0000;
  logic       seq_ok;
  logic [3:0] step_leds;
  logic [1:0] fail_cnt;
  logic       locked;
  logic       cfg_err;

  int n_checks = 0;
  int n_err = 0;

  // Model: phase 0 idle, 1..3 = bits collected, 4 = accepted, 5 = lockout
  int m_phase = 0;
  int m_word = 0;
  int m_pat = 11;
  int m_fail = 0;
  int m_lock_left = 0;
  int leds_tab[6] = '{0, 8, 4, 2, 1, 15};

  always #5 clk = ~clk;

  seq_lock_ctrl #(.SAMPLE_BIT(2), .STEP_BIT(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .boton       (boton),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .seq_ok      (seq_ok),
    .step_leds   (step_leds),
    .fail_cnt    (fail_cnt),
    .locked      (locked),
    .cfg_err     (cfg_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input int expv);
    n_checks++;
    assert (obs === 32'(expv)) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic model_step(input int b);
    case (m_phase)
      0: if (b != 0) begin m_phase = 1; m_word = 1; end
      1, 2: begin m_word = m_word * 2 + b; m_phase++; end
      3: begin
        m_word = m_word * 2 + b;
        if (m_word == m_pat) begin
          m_phase = 4;
          m_fail = 0;
        end else begin
          m_fail++;
          if (m_fail == 3) begin m_phase = 5; m_lock_left = 8; end
          else m_phase = 0;
        end
      end
      4: m_phase = 0;
      default: begin
        m_lock_left--;
        if (m_lock_left == 0) begin m_phase = 0; m_fail = 0; end
      end
    endcase
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, ".step_leds"}, 32'(step_leds), leds_tab[m_phase]);
    chk({tag, ".seq_ok"},    32'(seq_ok),    (m_phase == 4) ? 1 : 0);
    chk({tag, ".locked"},    32'(locked),    (m_phase == 5) ? 1 : 0);
    chk({tag, ".fail_cnt"},  32'(fail_cnt),  m_fail);
  endtask

  // One step period: entered and left on a negedge, step edge is the 16th posedge.
  task automatic run_period(input int b, input int cfg_at, input logic [3:0] cfg_val, input bit glitch);
    for (int c = 1; c <= 16; c++) begin
      boton       = (glitch && c >= 5 && c <= 7) ? 1'b1 : 1'(b);
      cfg_we      = (c == cfg_at);
      cfg_pattern = cfg_val;
      @(posedge clk);
      #1;
      if (c == cfg_at) begin
        chk("cfg_err_pulse", 32'(cfg_err), (m_phase != 0) ? 1 : 0);
        if (m_phase == 0) m_pat = 8 + (cfg_val % 8);
      end else if (c == cfg_at + 1) begin
        chk("cfg_err_clear", 32'(cfg_err), 0);
      end
      if (c == 8) chk("mid_leds", 32'(step_leds), leds_tab[m_phase]);
      if (c == 16) begin
        model_step(b);
        chk_outputs("step");
      end
      @(negedge clk);
    end
    cfg_we = 1'b0;
  endtask

  task automatic seq4(input int w);
    for (int i = 3; i >= 0; i--) run_period((w >> i) & 1, 0, 4'b0000, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk_outputs("reset");
    chk("reset.cfg_err", 32'(cfg_err), 0);
    rst_n = 1'b1;

    // Default code 1011 accepted, then back to idle
    seq4(4'b1011);
    run_period(0, 0, 4'b0000, 1'b0);

    // Three misses lock, boton held high during lockout is ignored
    seq4(4'b1111);
    seq4(4'b1111);
    seq4(4'b1111);
    for (int i = 0; i < 8; i++) run_period(1, 0, 4'b0000, 1'b0);
    run_period(0, 0, 4'b0000, 1'b0);

    // Short glitch between sample ticks never reaches the FSM
    run_period(0, 0, 4'b0000, 1'b1);
    run_period(0, 0, 4'b0000, 1'b1);

    // Reprogram in IDLE (MSB forced), then a rejected write in B2
    run_period(0, 3, 4'b0110, 1'b0);
    seq4(4'b1110);
    run_period(0, 0, 4'b0000, 1'b0);
    run_period(1, 0, 4'b0000, 1'b0);
    run_period(1, 0, 4'b0000, 1'b0);
    run_period(1, 5, 4'b0001, 1'b0);
    run_period(0, 0, 4'b0000, 1'b0);
    run_period(0, 0, 4'b0000, 1'b0);

    // Write on the same cycle as the step tick in IDLE
    run_period(1, 16, 4'b0011, 1'b0);
    run_period(0, 0, 4'b0000, 1'b0);
    run_period(1, 0, 4'b0000, 1'b0);
    run_period(1, 0, 4'b0000, 1'b0);
    run_period(0, 0, 4'b0000, 1'b0);

    // Two misses then a correct code clears the miss count
    seq4(4'b1111);
    seq4(4'b1110);
    seq4(4'b1011);
    run_period(0, 0, 4'b0000, 1'b0);

    // Reset mid-attempt in B3 after a custom code and a miss
    run_period(0, 2, 4'b0110, 1'b0);
    seq4(4'b1111);
    run_period(1, 0, 4'b0000, 1'b0);
    run_period(0, 0, 4'b0000, 1'b0);
    run_period(1, 0, 4'b0000, 1'b0);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    m_phase = 0; m_fail = 0; m_pat = 11; m_word = 0; m_lock_left = 0;
    chk_outputs("async_reset");
    chk("async_reset.cfg_err", 32'(cfg_err), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_period(0, 0, 4'b0000, 1'b0);
    seq4(4'b1011);
    run_period(0, 0, 4'b0000, 1'b0);

    // Random button levels and configuration writes
    for (int i = 0; i < 80; i++) begin
      int b;
      int at;
      b  = int'($urandom_range(0, 1));
      at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 16)) : 0;
      run_period(b, at, 4'($urandom_range(0, 15)), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/seq_lock_ctrl.md
SEQ_LOCK_CTRL -- requirements
Module: seq_lock_ctrl

Interface
REQ-001 SHALL have parameter SAMPLE_BIT, default 19, meaning debounce sample tick every 2^SAMPLE_BIT clk cycles.
REQ-002 SHALL have parameter STEP_BIT, default 24, meaning step tick every 2^STEP_BIT clk cycles; SAMPLE_BIT < STEP_BIT.
REQ-003 SHALL have port clk  input  1  single system clock, 50 MHz, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port boton  input  1  raw pushbutton, asynchronous to clk, bouncing.
REQ-006 SHALL have port cfg_we  input  1  one-cycle write strobe for cfg_pattern.
REQ-007 SHALL have port cfg_pattern  input  4  target sequence, MSB entered first.
REQ-008 SHALL have port seq_ok  output  1  high while in OK state.
REQ-009 SHALL have port step_leds  output  4  progress indicator.
REQ-010 SHALL have port fail_cnt  output  2  consecutive failed attempts.
REQ-011 SHALL have port locked  output  1  high while in LOCK state.
REQ-012 SHALL have port cfg_err  output  1  one-cycle pulse on rejected cfg_we.

Function
REQ-013 SHALL run one STEP_BIT-wide free-running counter div; sample_tick = div[SAMPLE_BIT-1:0] all ones; step_tick = div[STEP_BIT-1:0] all ones; all logic clocked by clk only, no derived clocks.
REQ-014 SHALL debounce boton: d1<=boton, d2<=d1 on sample_tick; btn_db = d1 & d2.
REQ-015 SHALL have states IDLE, B1, B2, B3, OK, LOCK; transitions only on step_tick.
REQ-016 IDLE: btn_db=1 -> B1, capture bit3=1; else stay (attempts always start with a 1).
REQ-017 B1 -> B2 capturing bit2=btn_db; B2 -> B3 capturing bit1=btn_db.
REQ-018 B3: form word {1,bit2,bit1,btn_db}; equal to stored pattern -> OK, fail_cnt<=0; else fail_cnt+1 and -> LOCK if new count = 3, else IDLE.
REQ-019 OK -> IDLE on next step_tick (seq_ok high exactly one step period).
REQ-020 LOCK: btn_db ignored; 3-bit lock_cnt increments per step_tick; on lock_cnt=7 -> IDLE, lock_cnt<=0, fail_cnt<=0 (8 step periods).
REQ-021 step_leds SHALL be IDLE 0000, B1 1000, B2 0100, B3 0010, OK 0001, LOCK 1111; registered, Moore.
REQ-022 cfg_we in IDLE SHALL load pattern register with {1,cfg_pattern[2:0]} next cycle (bit3 forced 1); cfg_we in any other state SHALL be ignored and pulse cfg_err one cycle later.
REQ-023 cfg_we and step_tick in same IDLE cycle: write takes effect, state transition also taken; pattern cannot change mid-attempt.
REQ-024 fail_cnt SHALL never exceed 3; div wraps from all ones to 0.

Reset
REQ-025 rst_n=0 SHALL asynchronously force: state IDLE, div 0, d1/d2 0, pattern 4'b1011, lock_cnt 0, fail_cnt 0, seq_ok 0, locked 0, cfg_err 0, step_leds 0000.
REQ-026 Reset asserted mid-attempt or in LOCK SHALL abandon it; release resumes from IDLE with no spurious seq_ok.

Structure
REQ-027 Package seq_lock_pkg SHALL hold state encoding (3-bit), MAX_FAIL=3, LOCK_STEPS=8, RESET_PATTERN=4'b1011.
REQ-028 Debouncer SHALL be sub-module btn_debounce (clk, rst_n, sample_tick, boton, btn_db); rest in one module.

Verification (SAMPLE_BIT=2, STEP_BIT=4: step every 16 cycles)
REQ-029 Default pattern, boton held 1,0,1,1 per step period -> B1,B2,B3 leds 1000,0100,0010, then seq_ok=1 and step_leds=0001 for 16 cycles, fail_cnt=0.
REQ-030 boton 1,1,1,1 three times -> fail_cnt 1,2 then locked=1, step_leds=1111 for 8 step periods, boton=1 during LOCK ignored, then IDLE, fail_cnt=0.
REQ-031 Glitch: boton high for 3 cycles only between sample ticks -> btn_db stays 0, state stays IDLE.
REQ-032 cfg_we=1 cfg_pattern=4'b0110 in IDLE -> pattern 1110; sequence 1,1,1,0 -> seq_ok; cfg_we in B2 -> cfg_err pulse, pattern unchanged.
REQ-033 rst_n low for 2 cycles while in B3 -> all outputs 0 immediately, pattern 1011, next step_tick with boton=0 stays IDLE.
REQ-034 fail_cnt=2 then correct sequence -> seq_ok, fail_cnt=0, no LOCK.
